tinker_fetch_unit: RTL and testbench

- Instruction fetch front end for tinker_core. It produces the 32-bit instruction words that the instruction decoder consumes.
- Holds the fetch PC and issues word reads to instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small FIFO and presents them to the core over a valid/ready instruction channel.
- Supports a single-cycle redirect (branch/jump/return) that flushes the buffer and discards responses already in flight.

---
 rtl/tinker_fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_tinker_fetch_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tinker_fetch_unit.sv
// Instruction fetch front end: fetch PC, credit-limited memory requests, in-order response buffer.
// Request-to-inst_valid latency is memory latency + 1; credits cap buffered plus in-flight words at DEPTH.

// Generic FIFO with synchronous flush; the caller guarantees no push when full and no pop when empty.
// Head data is read combinationally from registers; simultaneous push and pop on a full FIFO is legal.
module tinker_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     push_dat,
  input  logic             pop,
  output logic [W-1:0]     pop_dat,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_dat = mem_q[rd_ptr_q];
  assign count   = count_q;
endmodule

module tinker_fetch_unit #(
  parameter int              ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h2000,
  parameter int              DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  logic [ADDR_W-1:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]       drop_q, drop_d;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       outstanding;
  logic [ADDR_W-1:0]      resp_pc;
  logic [32+ADDR_W-1:0]   buf_dat;
  logic                   credit_ok;
  logic                   req_fire;
  logic                   resp_ok;
  logic                   resp_keep;
  logic                   pop_fire;

  assign credit_ok     = ({1'b0, count} + {1'b0, outstanding}) < SUM_W'(DEPTH);
  assign mem_req_valid = !reset && !redirect_valid && credit_ok;
  assign mem_req_addr  = fetch_pc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_ok   = !reset && mem_resp_valid && (outstanding != '0);
  assign resp_keep = resp_ok && (drop_q == '0);

  assign inst_valid = (count != '0);
  assign pop_fire   = inst_valid && inst_ready && !redirect_valid;

  // Issue addresses of in-flight requests; its occupancy is the outstanding count.
  tinker_fifo #(.W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_pc_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (1'b0),
    .push     (req_fire),
    .push_dat (fetch_pc_q),
    .pop      (resp_ok),
    .pop_dat  (resp_pc),
    .count    (outstanding)
  );

  // Redirect flushes the buffer; a same-cycle kept response is stale and is flushed with it.
  tinker_fifo #(.W(32 + ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_inst_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (resp_keep),
    .push_dat ({mem_resp_data, resp_pc}),
    .pop      (pop_fire),
    .pop_dat  (buf_dat),
    .count    (count)
  );

  assign instruction = buf_dat[32+ADDR_W-1:ADDR_W];
  assign inst_pc     = buf_dat[ADDR_W-1:0];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    if (resp_ok && (drop_q != '0)) begin
      drop_d = drop_q - CNT_W'(1);
    end
    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    end
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~ADDR_W'(3);
      drop_d     = outstanding - CNT_W'(resp_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

  resp_has_credit: assert property (@(posedge clk) disable iff (reset)
    mem_resp_valid |-> (outstanding != '0));
  credit_bound: assert property (@(posedge clk) disable iff (reset)
    ({1'b0, count} + {1'b0, outstanding}) <= SUM_W'(DEPTH));
  drop_bound: assert property (@(posedge clk) disable iff (reset)
    drop_q <= outstanding);
endmodule

// File: tb/tb_tinker_fetch_unit.sv
// Scoreboarded bench for tinker_fetch_unit with an in-order, fixed-latency instruction memory model.
module tb_tinker_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  tinker_fetch_unit #(.ADDR_W(64), .RESET_PC(64'h2000), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .instruction    (instruction),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] req_addr;
    logic [63:0] exp_addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [63:0] exp_buf[$];
  logic [63:0] log_pc[$];
  logic [63:0] model_pc;
  int          drop;
  int          lat;
  int          cyc;
  int          total;
  int          bad;
  bit          resp_now;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge with this cycle's inputs already driven; returns at the next negedge.
  task automatic tick();
    logic [63:0] e;
    mreq_t       m;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = mem_q[0].req_addr[31:0];
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
    end
    #1;
    if (!reset) begin
      chk("req_vld", mem_req_valid,
          !redirect_valid && (exp_buf.size() + mem_q.size() < DEPTH));
      chk("inst_vld", inst_valid, exp_buf.size() != 0);
      if (inst_valid && inst_ready && !redirect_valid && exp_buf.size() != 0) begin
        e = exp_buf.pop_front();
        chk("inst_pc", inst_pc, e);
        chk("inst_dat", instruction, {32'h0, e[31:0]});
        log_pc.push_back(inst_pc);
      end
      if (mem_resp_valid) begin
        m = mem_q.pop_front();
        if (drop > 0) drop--;
        else if (!redirect_valid) exp_buf.push_back(m.exp_addr);
      end
      if (redirect_valid) begin
        exp_buf.delete();
        drop     = mem_q.size();
        model_pc = {redirect_pc[63:2], 2'b00};
      end
      if (mem_req_valid && mem_req_ready) begin
        chk("req_addr", mem_req_addr, model_pc);
        m.req_addr = mem_req_addr;
        m.exp_addr = model_pc;
        m.due      = cyc + lat;
        mem_q.push_back(m);
        model_pc = model_pc + 64'd4;
      end
    end
    @(posedge clk);
    cyc++;
    if (reset) begin
      mem_q.delete();
      exp_buf.delete();
      drop     = 0;
      model_pc = 64'h2000;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    log_pc.delete();
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; drop = 0; lat = 1;
    model_pc       = 64'h2000;
    reset          = 1'b1;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    @(negedge clk);

    // Reset values while reset is held.
    tick();
    #1;
    chk("rst_req_vld", mem_req_valid, 1'b0);
    chk("rst_inst_vld", inst_valid, 1'b0);
    chk("rst_inst", instruction, 32'h0);
    chk("rst_pc", inst_pc, 64'h0);
    chk("rst_addr", mem_req_addr, 64'h2000);
    reset = 1'b0;

    // Streaming with 1-cycle memory and an always-ready core.
    log_pc.delete();
    for (int i = 0; i < 20; i++) tick();
    chk("a_cnt", log_pc.size() >= 2, 1'b1);
    if (log_pc.size() >= 2) begin
      chk("a_pc0", log_pc[0], 64'h2000);
      chk("a_pc1", log_pc[1], 64'h2004);
    end

    // Stalled core: credits run out after two requests, one pop releases one request.
    do_reset();
    inst_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    #1;
    chk("stall_req_vld", mem_req_valid, 1'b0);
    chk("stall_inst_vld", inst_valid, 1'b1);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    #1;
    chk("refill_vld", mem_req_valid, 1'b1);
    chk("refill_addr", mem_req_addr, 64'h2008);
    tick();
    inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    // Redirect with two words in flight: both must be discarded.
    do_reset();
    lat = 3;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3006;
    tick();
    redirect_valid = 1'b0;
    log_pc.delete();
    #1;
    chk("redir_addr", mem_req_addr, 64'h3004);
    for (int i = 0; i < 14; i++) tick();
    chk("redir_cnt", log_pc.size() >= 1, 1'b1);
    if (log_pc.size() >= 1) chk("redir_pc0", log_pc[0], 64'h3004);

    // Random traffic, biased toward redirects that coincide with a response and a consume.
    do_reset();
    lat = 2;
    for (int i = 0; i < 400; i++) begin
      mem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready    = ($urandom_range(0, 4) < 3);
      redirect_pc   = {$urandom, $urandom};
      resp_now      = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
      redirect_valid = ($urandom_range(0, 19) == 0) ||
                       (resp_now && inst_valid && inst_ready && ($urandom_range(0, 2) == 0));
      tick();
    end
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b1;
    inst_ready     = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    // Address wrap at the top of the address space.
    do_reset();
    lat = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    log_pc.delete();
    for (int i = 0; i < 10; i++) tick();
    chk("wrap_cnt", log_pc.size() >= 2, 1'b1);
    if (log_pc.size() >= 2) begin
      chk("wrap_pc0", log_pc[0], 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_pc1", log_pc[1], 64'h0);
    end

    // Memory not ready: request held stable, then a reset in the middle.
    do_reset();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) reset = 1'b1;
      #1;
      if (i == 3) begin
        chk("mid_rst_req_vld", mem_req_valid, 1'b0);
      end else begin
        chk("hold_vld", mem_req_valid, 1'b1);
        chk("hold_addr", mem_req_addr, 64'h2000);
      end
      tick();
      if (i == 3) begin
        reset = 1'b0;
        #1;
        chk("post_rst_inst_vld", inst_valid, 1'b0);
        chk("post_rst_inst", instruction, 32'h0);
        chk("post_rst_pc", inst_pc, 64'h0);
        chk("post_rst_addr", mem_req_addr, 64'h2000);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
